// File: rtl/imem_port.sv
// Instruction memory responder: fetch address in, word out two edges later (1/cycle).
// stall freezes both read stages; byte writes patch the array and any in-flight word.
module imem_port #(
  parameter int         ADDR_BITS  = 14,
  parameter logic [7:0] FAULT_CODE = 8'h82
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] fetch_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic [31:0] instr_out,
  output logic [7:0]  fault_out,
  output logic        valid_out
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [ADDR_BITS-1:0] fetch_idx;
  logic [ADDR_BITS-1:0] wr_idx;
  logic                 fetch_ok;
  logic                 wr_ok;
  logic                 wr_hit;

  assign fetch_idx = fetch_addr[ADDR_BITS+1:2];
  assign wr_idx    = wr_addr[ADDR_BITS+1:2];
  assign fetch_ok  = (fetch_addr[31:ADDR_BITS+2] == '0);
  assign wr_ok     = (wr_addr[31:ADDR_BITS+2] == '0);
  assign wr_hit    = wr_en && wr_ok;

  // Stage R1 state
  logic [ADDR_BITS-1:0] r1_idx;
  logic                 r1_ok;
  logic                 r1_valid;
  logic [31:0]          r1_data;
  logic [7:0]           r1_fault;

  // Stage R2 word tracking (data lives in instr_out)
  logic [ADDR_BITS-1:0] r2_idx;
  logic                 r2_ok;

  logic        hit_fetch;
  logic        hit_r1;
  logic        hit_r2;
  logic [31:0] fetch_word;
  logic [31:0] r1_fwd;
  logic [31:0] r2_fwd;

  assign hit_fetch = wr_hit && fetch_ok && (wr_idx == fetch_idx);
  assign hit_r1    = wr_hit && r1_valid && r1_ok && (wr_idx == r1_idx);
  assign hit_r2    = wr_hit && valid_out && r2_ok && (wr_idx == r2_idx);

  // Merged views: what each stage would hold if the current write lands on it.
  always_comb begin
    fetch_word = '0;
    if (fetch_ok) begin
      fetch_word = hit_fetch ? merge_bytes(mem[fetch_idx], wr_data, wr_be)
                             : mem[fetch_idx];
    end
    r1_fwd = hit_r1 ? merge_bytes(r1_data, wr_data, wr_be) : r1_data;
    r2_fwd = hit_r2 ? merge_bytes(instr_out, wr_data, wr_be) : instr_out;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_idx    <= '0;
      r1_ok     <= 1'b0;
      r1_valid  <= 1'b0;
      r1_data   <= '0;
      r1_fault  <= '0;
      r2_idx    <= '0;
      r2_ok     <= 1'b0;
      instr_out <= '0;
      fault_out <= '0;
      valid_out <= 1'b0;
    end else if (!stall) begin
      r1_idx    <= fetch_idx;
      r1_ok     <= fetch_ok;
      r1_valid  <= 1'b1;
      r1_data   <= fetch_word;
      r1_fault  <= fetch_ok ? 8'h00 : FAULT_CODE;
      r2_idx    <= r1_idx;
      r2_ok     <= r1_ok;
      instr_out <= r1_fwd;
      fault_out <= r1_fault;
      valid_out <= r1_valid;
    end else begin
      r1_data   <= r1_fwd;
      instr_out <= r2_fwd;
    end
  end

endmodule

// File: doc/imem_port.md
# imem_port

Instruction-side memory responder that services the two-stage fetch front end. It accepts one fetch address per cycle and returns the addressed instruction word two clock edges later, matching the fetch pipeline's two-cycle memory assumption. It holds both read stages in place while the pipeline is stalled. A byte-enabled write port supports the loader and self-modifying stores; in-flight reads to a written word see the new bytes.

## Interface
- ADDR_BITS, 14: word-address width; capacity is 2^ADDR_BITS 32-bit words (byte range 0 .. 4*2^ADDR_BITS-1).
- FAULT_CODE, 8'h82: code reported on `fault_out` for an out-of-range fetch.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold both read stages (same stall as the fetch stages).
- fetch_addr  in  32  byte address of the instruction to read; bits [1:0] ignored.
- wr_en  in  1  write request this cycle.
- wr_addr  in  32  byte address of write; bits [1:0] ignored.
- wr_data  in  32  write data, little-endian byte lanes.
- wr_be  in  4  byte enables; bit i selects wr_data[8i+7:8i].
- instr_out  out  32  instruction word for the address presented two edges earlier.
- fault_out  out  8  0, or FAULT_CODE if that address was out of range.
- valid_out  out  1  instr_out/fault_out carry a real response (low until two reads have completed after reset).

## Operation
- Word index = addr[ADDR_BITS+1:2]; in range iff addr[31:ADDR_BITS+2] == 0.
- Stage R1 (on edge, if !stall): capture index, range flag, valid=1 and array word into r1_data (synchronous read). Out of range: r1_data = 0, r1_fault = FAULT_CODE.
- Stage R2 (on edge, if !stall): instr_out <= r1_data, fault_out <= r1_fault, valid_out <= r1_valid.
- stall high: R1 and R2 registers keep their values (except the write merge below); the array does not advance the read.
- Write (any cycle, stall or not, not in rst): if wr_en and wr_addr in range, update enabled bytes of the array word. Out-of-range writes and wr_be == 0 change nothing.
- Write-first: a write and a fetch to the same word in the same non-stalled cycle make R1 capture the merged (new) bytes.
- Forwarding: if a write hits the word held in R1 (in range), merge the enabled bytes into r1_data on that edge. The same applies to R2's held word and instr_out. This holds whether or not stall is asserted. When the pipeline advances on the same edge, the merge applies to the data entering each stage.
- R2 tracks its own word index for this comparison.
- rst: valid pipe (R1, R2) cleared to 0. instr_out = 32'h0, fault_out = 8'h0, r1_data = 0. The array is not cleared. rst overrides stall and wr_en.

## Timing
- Latency: fetch_addr sampled at edge E (stall low at E and E+1) -> instr_out valid after edge E+1. Throughput is 1 word/cycle.
- Each cycle stall is high at an edge delays the response by exactly one cycle. Outputs are stable during the stall, modulo forwarding merges.
- After rst deasserts: valid_out = 0 after the first edge, and 1 after the second non-stalled edge.
- Write visibility: a fetch sampled at the same edge as the write, or later, returns new data. Reads already in R1/R2 are patched on the write edge.
- Reset mid-operation: in-flight reads are discarded and valid_out drops on the rst edge. Writes in the rst cycle are dropped.
- Address wrap: none. Any address beyond capacity faults; 32'hFFFFFFFC faults rather than aliasing.

## Test plan
- Streaming: preload word 0x100 = 0xDEADBEEF, 0x101 = 0x12345678. Present 0x400 then 0x404 on consecutive unstalled edges -> instr_out = 0xDEADBEEF after the second edge, 0x12345678 after the third; valid_out = 1, fault_out = 0.
- Stall hold: issue 0x400, raise stall for 3 edges, then drop -> instr_out/valid_out frozen during stall; 0xDEADBEEF appears exactly 3 cycles later than in the unstalled case.
- Forwarding: fetch 0x404, then on the next edge write wr_addr = 0x404, wr_be = 4'b0011, wr_data = 0x0000AAAA -> instr_out = 0x1234AAAA. Repeat with the write while stalled and R2 holds the word -> instr_out changes to the merged value.
- Write-first: same-edge write 0xCAFEF00D (be = 4'hF) and fetch to 0x408 -> instr_out = 0xCAFEF00D two edges later.
- Range: ADDR_BITS = 14, fetch 0x00010000 -> fault_out = 8'h82, instr_out = 0. Write to 0x00010000 -> no array word changes.
- Reset: assert rst with two reads in flight -> valid_out = 0, instr_out = 0, fault_out = 0 after the edge; previously written words still read back correctly afterward.
